// File: rtl/noc_pkg.sv
// Shared definitions for the NoC switch allocator.
//   Direction codes double as port indices (EAST=0 .. LOCAL=4).
//   Each output carries a small context (IDLE/LOCKED plus the owning
//   input). It is kept as a packed struct so checkers can bind to one
//   signal per output.
package noc_pkg;

    localparam int NUM_PORTS = 5;
    localparam int DIR_BITS  = 3;
    localparam int CREDITS   = 4;
    localparam int CRED_BITS = $clog2(CREDITS + 1);
    localparam int SEL_BITS  = $clog2(NUM_PORTS);

    typedef logic [DIR_BITS-1:0]  dir_t;
    typedef logic [SEL_BITS-1:0]  sel_t;
    typedef logic [CRED_BITS-1:0] cred_t;

    localparam dir_t EAST  = dir_t'(0);
    localparam dir_t WEST  = dir_t'(1);
    localparam dir_t NORTH = dir_t'(2);
    localparam dir_t SOUTH = dir_t'(3);
    localparam dir_t LOCAL = dir_t'(4);

    localparam cred_t CRED_FULL = cred_t'(CREDITS);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } out_state_e;

    typedef struct packed {
        out_state_e state;
        sel_t       owner;
    } out_ctx_t;

    // Index of the set bit in a one-hot (or all-zero) vector.
    function automatic sel_t onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
        sel_t idx;
        idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (oh[i]) idx = idx | sel_t'(i);
        end
        return idx;
    endfunction

    // Round-robin successor: (p + 1) mod NUM_PORTS.
    function automatic sel_t next_port(input sel_t p);
        return (p == sel_t'(NUM_PORTS - 1)) ? '0 : sel_t'(p + 1'b1);
    endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// N-way round-robin arbiter, purely combinational.
//   req_i : request vector
//   ptr_i : index with highest priority this cycle
//   gnt_o : one-hot grant (all zero when nothing requests)
// Requesters are scanned in increasing index order, starting at ptr_i and
// wrapping around. The first requester found wins.
module noc_rr_arbiter #(
    parameter int N        = 5,
    parameter int PTR_BITS = 3
) (
    input  logic [N-1:0]        req_i,
    input  logic [PTR_BITS-1:0] ptr_i,
    output logic [N-1:0]        gnt_o
);

    logic                found;
    logic [PTR_BITS-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_BITS'((int'(ptr_i) + k) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_switch_allocator.sv
// Wormhole switch allocator with credit-based flow control.
//   clk, rst      : clock, asynchronous active-high reset
//   in_valid      : input i holds a flit
//   in_dir        : requested output of input i (DIR_BITS per input)
//   in_tail       : flit at input i is a tail (single-flit packet: head = tail)
//   in_ready      : combinational grant; a flit moves on in_valid & in_ready
//   credit_return : the downstream buffer of output o freed one slot
//   xbar_sel      : registered crossbar select per output
//   out_valid     : registered, output o carries a flit this cycle
//   credit_cnt    : current credits per output
// Handshake: a flit transfers in any cycle where in_valid[i] and in_ready[i]
// are both high. in_ready depends on the current inputs, so upstream must not
// make in_valid depend on in_ready.
// An output is granted only when it has at least one credit. A head flit that
// is not also a tail locks the output to its input until the tail passes. The
// lock is kept while the output waits for credits.
module noc_switch_allocator
    import noc_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           in_valid,
    input  logic [NUM_PORTS*DIR_BITS-1:0]  in_dir,
    input  logic [NUM_PORTS-1:0]           in_tail,
    output logic [NUM_PORTS-1:0]           in_ready,
    input  logic [NUM_PORTS-1:0]           credit_return,
    output logic [NUM_PORTS*SEL_BITS-1:0]  xbar_sel,
    output logic [NUM_PORTS-1:0]           out_valid,
    output logic [NUM_PORTS*CRED_BITS-1:0] credit_cnt
);

    // Per-output state
    out_ctx_t ctx_q      [NUM_PORTS];
    out_ctx_t ctx_d      [NUM_PORTS];
    sel_t     rr_ptr_q   [NUM_PORTS];
    sel_t     rr_ptr_d   [NUM_PORTS];
    cred_t    cred_q     [NUM_PORTS];
    cred_t    cred_d     [NUM_PORTS];
    sel_t     xbar_sel_q [NUM_PORTS];
    logic [NUM_PORTS-1:0] out_valid_q;

    // Per-output combinational terms
    logic [NUM_PORTS-1:0] req     [NUM_PORTS];  // req[o][i]: input i wants output o
    logic [NUM_PORTS-1:0] arb_gnt [NUM_PORTS];
    logic [NUM_PORTS-1:0] grant   [NUM_PORTS];
    sel_t                 win_idx [NUM_PORTS];
    logic [NUM_PORTS-1:0] xfer;
    logic [NUM_PORTS-1:0] rdy_any;

    // A direction code of NUM_PORTS or above matches no output, so that
    // request is never granted.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                req[o][i] = in_valid[i] &&
                            (dir_t'(in_dir[i*DIR_BITS +: DIR_BITS]) == dir_t'(o));
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        noc_rr_arbiter #(
            .N        (NUM_PORTS),
            .PTR_BITS (SEL_BITS)
        ) u_arb (
            .req_i (req[o]),
            .ptr_i (rr_ptr_q[o]),
            .gnt_o (arb_gnt[o])
        );

        // Returning a credit to an output that already holds all of them
        // means the downstream bookkeeping is broken. The count saturates.
        a_credit_overflow: assert property (@(posedge clk) disable iff (rst)
            !(credit_return[o] && !xfer[o] && cred_q[o] == CRED_FULL))
            else $warning("noc_switch_allocator: credit returned to full output %0d", o);
    end

    // A locked output only considers its owner. The arbiter result is used
    // only while the output is idle.
    always_comb begin
        rdy_any = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            grant[o] = '0;
            if (cred_q[o] != '0) begin
                if (ctx_q[o].state == IDLE) begin
                    grant[o] = arb_gnt[o];
                end else begin
                    grant[o][ctx_q[o].owner] = req[o][ctx_q[o].owner];
                end
            end
            xfer[o]    = |grant[o];
            win_idx[o] = onehot_to_idx(grant[o]);
            rdy_any    = rdy_any | grant[o];
        end
    end

    assign in_ready = rst ? '0 : rdy_any;

    // Next state for the lock, the round-robin pointer and the credits.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            ctx_d[o]    = ctx_q[o];
            rr_ptr_d[o] = rr_ptr_q[o];
            cred_d[o]   = cred_q[o];

            if (xfer[o]) begin
                if (ctx_q[o].state == IDLE) begin
                    rr_ptr_d[o] = next_port(win_idx[o]);
                    if (!in_tail[win_idx[o]]) begin
                        ctx_d[o].state = LOCKED;
                        ctx_d[o].owner = win_idx[o];
                    end
                end else if (in_tail[win_idx[o]]) begin
                    ctx_d[o].state = IDLE;
                end
            end

            unique case ({xfer[o], credit_return[o]})
                2'b10: cred_d[o] = cred_q[o] - 1'b1;
                2'b01: if (cred_q[o] != CRED_FULL) cred_d[o] = cred_q[o] + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                ctx_q[o]      <= '{state: IDLE, owner: '0};
                rr_ptr_q[o]   <= '0;
                cred_q[o]     <= CRED_FULL;
                xbar_sel_q[o] <= '0;
            end
            out_valid_q <= '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                ctx_q[o]    <= ctx_d[o];
                rr_ptr_q[o] <= rr_ptr_d[o];
                cred_q[o]   <= cred_d[o];
                if (xfer[o]) xbar_sel_q[o] <= win_idx[o];
            end
            out_valid_q <= xfer;
        end
    end

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            xbar_sel[o*SEL_BITS +: SEL_BITS]    = xbar_sel_q[o];
            credit_cnt[o*CRED_BITS +: CRED_BITS] = cred_q[o];
        end
    end

    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_noc_switch_allocator.sv
module tb_noc_switch_allocator;

  localparam int NP = 5;
  localparam int CR = 4;

  logic        clk;
  logic        rst;
  logic [4:0]  in_valid;
  logic [14:0] in_dir;
  logic [4:0]  in_tail;
  logic [4:0]  in_ready;
  logic [4:0]  credit_return;
  logic [14:0] xbar_sel;
  logic [4:0]  out_valid;
  logic [14:0] credit_cnt;

  int total = 0;
  int bad   = 0;

  // expected output events: {output[2:0], input[2:0]}
  logic [5:0] exp_q[$];

  // reference model: per output, packet owner (-1 none), rr start, credits
  int m_owner[NP];
  int m_next[NP];
  int m_cred[NP];

  noc_switch_allocator dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_dir        (in_dir),
    .in_tail       (in_tail),
    .in_ready      (in_ready),
    .credit_return (credit_return),
    .xbar_sel      (xbar_sel),
    .out_valid     (out_valid),
    .credit_cnt    (credit_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] dirs5(input int d0, input int d1, input int d2,
                                        input int d3, input int d4);
    return {3'(d4), 3'(d3), 3'(d2), 3'(d1), 3'(d0)};
  endfunction

  function automatic int dir_of(input logic [14:0] dirs, input int k);
    return int'(dirs[k*3 +: 3]);
  endfunction

  function automatic void model_reset();
    for (int o = 0; o < NP; o++) begin
      m_owner[o] = -1;
      m_next[o]  = 0;
      m_cred[o]  = CR;
    end
  endfunction

  function automatic logic [14:0] model_cred_vec();
    logic [14:0] r;
    for (int o = 0; o < NP; o++) r[o*3 +: 3] = 3'(m_cred[o]);
    return r;
  endfunction

  // which input each output serves this cycle (-1 = none)
  function automatic void model_pick(input logic [4:0] v, input logic [14:0] dirs,
                                     output int gin[NP]);
    int k;
    for (int o = 0; o < NP; o++) begin
      gin[o] = -1;
      if (m_cred[o] > 0) begin
        if (m_owner[o] >= 0) begin
          k = m_owner[o];
          if (v[k] && dir_of(dirs, k) == o) gin[o] = k;
        end else begin
          for (int s = 0; s < NP; s++) begin
            k = (m_next[o] + s) % NP;
            if (gin[o] < 0 && v[k] && dir_of(dirs, k) == o) gin[o] = k;
          end
        end
      end
    end
  endfunction

  function automatic void model_update(input int gin[NP], input logic [4:0] tl,
                                       input logic [4:0] ret);
    int c;
    int w;
    for (int o = 0; o < NP; o++) begin
      c = m_cred[o];
      if (gin[o] >= 0) begin
        w = gin[o];
        c = c - 1;
        if (m_owner[o] < 0) begin
          m_next[o] = (w + 1) % NP;
          if (!tl[w]) m_owner[o] = w;
        end else if (tl[w]) begin
          m_owner[o] = -1;
        end
      end
      if (ret[o]) c = c + 1;
      if (c > CR) c = CR;
      m_cred[o] = c;
    end
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the next one.
  task automatic cycle(input logic [4:0] v, input logic [14:0] dirs, input logic [4:0] tl,
                       input logic [4:0] ret, output logic [4:0] rdy, output logic [4:0] mrdy);
    int gin[NP];
    #1;
    in_valid      = v;
    in_dir        = dirs;
    in_tail       = tl;
    credit_return = ret;
    model_pick(v, dirs, gin);
    mrdy = '0;
    for (int o = 0; o < NP; o++) if (gin[o] >= 0) mrdy[gin[o]] = 1'b1;
    @(negedge clk);
    check("in_ready", {27'd0, in_ready}, {27'd0, mrdy});
    check("credit_cnt", {17'd0, credit_cnt}, {17'd0, model_cred_vec()});
    for (int o = 0; o < NP; o++) begin
      if (gin[o] >= 0) exp_q.push_back({3'(o), 3'(gin[o])});
    end
    model_update(gin, tl, ret);
    rdy = in_ready;
    @(posedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [5:0] e;
    if (!rst) begin
      for (int o = 0; o < NP; o++) begin
        if (out_valid[o]) begin
          if (exp_q.size() == 0) begin
            check("out_valid_extra", {27'd0, out_valid}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("out_xbar_sel", {26'd0, 3'(o), xbar_sel[o*3 +: 3]}, {26'd0, e});
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [4:0]  rdy;
  logic [4:0]  mrdy;
  logic [4:0]  v;
  logic [4:0]  tl;
  logic [4:0]  ret;
  logic [14:0] dirs;
  logic [4:0]  t2_exp[6];
  int          p_dir[NP];
  int          p_left[NP];

  initial begin
    rst = 1'b1;
    in_valid = '0;
    in_dir = '0;
    in_tail = '0;
    credit_return = '0;
    model_reset();
    for (int i = 0; i < NP; i++) begin
      p_dir[i]  = 0;
      p_left[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);

    // 1. reset state
    #1;
    check("rst_credit_cnt", {17'd0, credit_cnt}, {17'd0, 15'b100_100_100_100_100});
    check("rst_out_valid", {27'd0, out_valid}, 32'd0);
    check("rst_in_ready", {27'd0, in_ready}, 32'd0);
    check("rst_xbar_sel", {17'd0, xbar_sel}, 32'd0);

    // 2. contention on LOCAL: inputs 0,2,3 single-flit packets every cycle
    t2_exp = '{5'b00001, 5'b00100, 5'b01000, 5'b00001, 5'b00100, 5'b01000};
    for (int k = 0; k < 6; k++) begin
      cycle(5'b01101, dirs5(4, 0, 4, 4, 0), 5'b11111, 5'b10000, rdy, mrdy);
      check("contention_grant", {27'd0, rdy}, {27'd0, t2_exp[k]});
    end

    // 3. wormhole: input 1 four-flit packet to EAST, input 4 waits
    for (int k = 0; k < 4; k++) begin
      cycle(5'b10010, dirs5(0, 0, 0, 0, 0), (k == 3) ? 5'b10010 : 5'b10000,
            5'b00001, rdy, mrdy);
      check("wormhole_hold", {27'd0, rdy}, 32'd2);
    end
    cycle(5'b10000, dirs5(0, 0, 0, 0, 0), 5'b10000, 5'b00001, rdy, mrdy);
    check("wormhole_release", {27'd0, rdy}, 32'd16);

    // 4. credits on NORTH: input 0 sends single flits without returns
    for (int k = 0; k < 6; k++) begin
      cycle(5'b00001, dirs5(2, 0, 0, 0, 0), 5'b00001, 5'b00000, rdy, mrdy);
      check("credit_drain", {27'd0, rdy}, (k < 4) ? 32'd1 : 32'd0);
    end
    #1;
    check("credit_empty", {29'd0, credit_cnt[8:6]}, 32'd0);
    cycle(5'b00001, dirs5(2, 0, 0, 0, 0), 5'b00001, 5'b00100, rdy, mrdy);
    check("credit_zero_block", {27'd0, rdy}, 32'd0);
    cycle(5'b00001, dirs5(2, 0, 0, 0, 0), 5'b00001, 5'b00000, rdy, mrdy);
    check("credit_one_grant", {27'd0, rdy}, 32'd1);
    cycle(5'b00000, dirs5(2, 0, 0, 0, 0), 5'b00001, 5'b00100, rdy, mrdy);
    cycle(5'b00001, dirs5(2, 0, 0, 0, 0), 5'b00001, 5'b00100, rdy, mrdy);
    check("credit_xfer_and_return", {27'd0, rdy}, 32'd1);
    #1;
    check("credit_kept", {29'd0, credit_cnt[8:6]}, 32'd1);
    repeat (3) cycle(5'b00000, '0, '0, 5'b00100, rdy, mrdy);

    // 5. bad direction codes and over-return
    for (int k = 0; k < 3; k++) begin
      cycle(5'b01010, dirs5(0, 5, 0, 7, 0), 5'b01010, 5'b00000, rdy, mrdy);
      check("bad_dir_no_grant", {27'd0, rdy}, 32'd0);
    end
    #1;
    check("bad_dir_credits", {17'd0, credit_cnt}, {17'd0, 15'b100_100_100_100_100});
    cycle(5'b00000, '0, '0, 5'b11111, rdy, mrdy);
    #1;
    check("over_return_sat", {17'd0, credit_cnt}, {17'd0, 15'b100_100_100_100_100});

    // 6. reset while SOUTH is locked to input 0
    cycle(5'b00001, dirs5(3, 0, 0, 0, 0), 5'b00000, 5'b00000, rdy, mrdy);
    check("lock_head", {27'd0, rdy}, 32'd1);
    cycle(5'b00001, dirs5(3, 0, 0, 0, 0), 5'b00000, 5'b00000, rdy, mrdy);
    check("lock_body", {27'd0, rdy}, 32'd1);
    #1;
    rst = 1'b1;
    exp_q.delete();
    in_valid = 5'b00101;
    in_dir   = dirs5(3, 0, 3, 0, 0);
    in_tail  = '0;
    credit_return = '0;
    model_reset();
    @(negedge clk);
    check("rst_mid_in_ready", {27'd0, in_ready}, 32'd0);
    check("rst_mid_out_valid", {27'd0, out_valid}, 32'd0);
    check("rst_mid_credits", {17'd0, credit_cnt}, {17'd0, 15'b100_100_100_100_100});
    @(posedge clk);
    @(negedge clk);
    in_valid = '0;
    rst = 1'b0;
    @(posedge clk);
    cycle(5'b00100, dirs5(0, 0, 3, 0, 0), 5'b00000, 5'b00000, rdy, mrdy);
    check("post_rst_grant", {27'd0, rdy}, 32'd4);
    cycle(5'b00100, dirs5(0, 0, 3, 0, 0), 5'b00100, 5'b00000, rdy, mrdy);
    check("post_rst_tail", {27'd0, rdy}, 32'd4);

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      v = '0;
      dirs = '0;
      tl = '0;
      ret = '0;
      for (int i = 0; i < NP; i++) begin
        if (p_left[i] == 0 && $urandom_range(0, 3) == 0) begin
          p_dir[i]  = $urandom_range(0, 4);
          p_left[i] = $urandom_range(1, 4);
        end
        if (p_left[i] > 0) begin
          v[i] = ($urandom_range(0, 3) != 0);
          dirs[i*3 +: 3] = 3'(p_dir[i]);
          tl[i] = (p_left[i] == 1);
        end else if ($urandom_range(0, 9) == 0) begin
          v[i] = 1'b1;
          dirs[i*3 +: 3] = 3'($urandom_range(5, 7));
        end
      end
      for (int o = 0; o < NP; o++) begin
        ret[o] = (m_cred[o] < CR) && ($urandom_range(0, 2) == 0);
      end
      cycle(v, dirs, tl, ret, rdy, mrdy);
      for (int i = 0; i < NP; i++) if (mrdy[i]) p_left[i] = p_left[i] - 1;
    end

    // drain
    for (int c = 0; c < 4; c++) begin
      for (int o = 0; o < NP; o++) ret[o] = (m_cred[o] < CR);
      cycle(5'b00000, '0, '0, ret, rdy, mrdy);
    end
    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
